ex_mem_pipe_reg: RTL
====================

Name: ex_mem_pipe_reg

Overview:
- Parametrised, flow-controlled successor to the fixed EX/MEM pipeline register.
- Carries ALU result, store data, destination register and memory/writeback control from EX to MEM.
- Uses a valid/ready handshake and a 2-entry skid buffer, so MEM back-pressure stalls EX without a combinational ready path.
- Supports pipeline flush for branch mispredict and bubble insertion; control outputs are forced inert whenever the stage holds no valid instruction.

Parameters:
- DATA_W, 32, width of alu_result and write_data.
- REG_W, 5, width of the destination register index.
- SKID_EN, 1, 1 = 2-entry skid buffer; 0 = single entry with in_ready = !out_valid || out_ready (combinational).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- flush  in  1  synchronous kill of all held and incoming entries.
- in_valid  in  1  EX presents a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- alu_result_in  in  DATA_W  ALU result / memory address.
- write_data_in  in  DATA_W  store data.
- write_reg_in  in  REG_W  destination register.
- reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in  in  1 each  control bits.
- out_valid  out  1  MEM-facing entry valid.
- out_ready  in  1  MEM consumes this cycle.
- alu_result_out, write_data_out  out  DATA_W  head-entry payload.
- write_reg_out  out  REG_W  head-entry destination.
- reg_write_out, mem_to_reg_out, mem_read_out, mem_write_out  out  1 each  head-entry control, gated by out_valid.
- occupancy  out  2  number of valid entries held (0..2).

Behaviour:
- Accept: in_valid && in_ready at a rising edge. Drain: out_valid && out_ready at a rising edge.
- Storage: head entry (drives outputs) and skid entry. With SKID_EN=1, in_ready = !skid_valid, a pure register function.
- Latency: an accept into an empty stage makes out_valid = 1 the next cycle with the captured payload. Throughput is 1 per cycle while out_ready = 1.
- Accept, head empty or draining same cycle: data goes to head.
- Accept, head full and not draining: data goes to skid, in_ready drops next cycle.
- Drain with skid valid: skid moves to head. A same-cycle accept is not possible, since in_ready = 0.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush.
- Flush: head_valid and skid_valid clear next cycle, and any same-cycle accept is discarded. Flush has priority over accept and drain.
- Payload registers may keep stale values after flush; valid and control gating make them inert.
- Bubble gating: reg_write_out, mem_read_out and mem_write_out = 0 whenever out_valid = 0. mem_to_reg_out is also gated.
- Stall: while out_valid && !out_ready, all head outputs are held bit-stable.
- Reset (reset = 0 at an edge): all outputs 0, including all payload, out_valid, occupancy and control; both valids cleared. in_ready = 1 from the first edge after reset is sampled low, for SKID_EN=1.
- Reset overrides flush and handshakes. Reset in the middle of a stall discards both entries.
- occupancy = head_valid + skid_valid, registered, and consistent with out_valid/in_ready in the same cycle.
- SKID_EN=0: the skid entry is never used, occupancy ≤ 1, and in_ready = !out_valid || out_ready.

Test Plan:
1. Reset then single beat: reset = 0 for 2 cycles, then in_valid = 1, alu_result_in = 0x0000_1234, write_reg_in = 5, reg_write_in = 1, out_ready = 1 -> next cycle out_valid = 1, alu_result_out = 0x1234, write_reg_out = 5, reg_write_out = 1; one cycle later out_valid = 0 and reg_write_out = 0.
2. Back-pressure: stream A = 0x10, B = 0x20, C = 0x30 with out_ready = 0 from the cycle A arrives -> head = A, skid = B, occupancy = 2, in_ready = 0, C held by EX. Raise out_ready -> outputs A, B, C in consecutive cycles, none lost or duplicated.
3. Flush while full: occupancy = 2, then flush = 1 with in_valid = 1 (D = 0x40) -> next cycle out_valid = 0, occupancy = 0, mem_write_out = 0, in_ready = 1; D never appears.
4. Bubble gating: in_valid = 0 with mem_write_in = 1, write_data_in = 0xDEAD_BEEF -> mem_write_out and reg_write_out stay 0 and out_valid stays 0.
5. Reset mid-stall: occupancy = 2, out_ready = 0, then reset = 0 for one edge -> all outputs 0, occupancy = 0; after reset = 1, the next accept appears normally.
6. SKID_EN=0 at full rate: out_ready toggling 1,0,1,1 with continuous in_valid -> in_ready mirrors !out_valid || out_ready, occupancy ≤ 1, and order is preserved.

Source files
------------

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with a valid/ready handshake and an optional 2-entry skid buffer; 1-cycle latency.
// With SKID_EN=1, in_ready is a pure register (!skid valid), so MEM back-pressure never reaches EX combinationally.
module ex_mem_pipe_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] write_data_in,
  input  logic [REG_W-1:0]  write_reg_in,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] write_data_out,
  output logic [REG_W-1:0]  write_reg_out,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [REG_W-1:0]  write_reg;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
  } ent_t;

  ent_t       in_ent;
  ent_t       head_q, head_d;
  ent_t       skid_q, skid_d;
  logic       head_vld_q, head_vld_d;
  logic       skid_vld_q, skid_vld_d;
  logic [1:0] occ_q, occ_d;
  logic       accept, drain;

  assign in_ent = '{alu_result: alu_result_in, write_data: write_data_in,
                    write_reg: write_reg_in, reg_write: reg_write_in,
                    mem_to_reg: mem_to_reg_in, mem_read: mem_read_in,
                    mem_write: mem_write_in};

  assign in_ready = SKID_EN ? !skid_vld_q : (!head_vld_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = head_vld_q && out_ready;

  always_comb begin
    head_d     = head_q;
    skid_d     = skid_q;
    head_vld_d = head_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (drain && skid_vld_q) begin
      // in_ready is low whenever the skid is full, so no accept can collide here
      head_d     = skid_q;
      skid_vld_d = 1'b0;
    end else if (accept && (!head_vld_q || drain)) begin
      head_d     = in_ent;
      head_vld_d = 1'b1;
    end else if (accept && SKID_EN) begin
      skid_d     = in_ent;
      skid_vld_d = 1'b1;
    end else if (drain) begin
      head_vld_d = 1'b0;
    end
    occ_d = {1'b0, head_vld_d} + {1'b0, skid_vld_d};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q     <= '0;
      skid_q     <= '0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      occ_q      <= occ_d;
    end
  end

  // Control is gated so a bubble or flushed entry can never write memory or the register file
  assign out_valid      = head_vld_q;
  assign alu_result_out = head_q.alu_result;
  assign write_data_out = head_q.write_data;
  assign write_reg_out  = head_q.write_reg;
  assign reg_write_out  = head_q.reg_write  && head_vld_q;
  assign mem_to_reg_out = head_q.mem_to_reg && head_vld_q;
  assign mem_read_out   = head_q.mem_read   && head_vld_q;
  assign mem_write_out  = head_q.mem_write  && head_vld_q;
  assign occupancy      = occ_q;

endmodule
